// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter that shares one logarithmic logical-right
// shifter between R requesters. The winning operand is shifted and captured
// into a one-entry output stage that has its own valid/ready handshake and
// carries the ID of the requester that produced it.
//
// Optional build macro SHIFT_ARB_STATS_EN adds two saturating 16-bit counters:
// ops_cnt (completed result handshakes) and busy_cycles (cycles stalled with
// a result held and res_ready low).
module shift_arbiter #(
  parameter int N = 16,
  parameter int R = 4,
  localparam int AW = $clog2(N),
  localparam int IW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [R*N-1:0]  req_data,
  input  logic [R*AW-1:0] req_amt,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N-1:0]    res_data,
  output logic [IW-1:0]   res_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]     ops_cnt,
  output logic [15:0]     busy_cycles
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] grant_idx;
  logic          grant_found;
  logic          can_accept;
  logic          transfer;
  logic [N-1:0]  sel_data;
  logic [AW-1:0] sel_amt;
  logic [N-1:0]  shifted;

  // A new operand can enter when the output stage is empty or is being drained this cycle.
  assign can_accept = (state == IDLE) || ((state == FULL) && res_ready);
  assign transfer   = can_accept && grant_found;
  assign res_valid  = (state == FULL);

  // Round-robin search: first asserted valid starting at rr_ptr, wrapping to 0.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < R; k++) begin
      cand = (int'(rr_ptr) + k) % R;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // Grant is one-hot on the winner, only when the output stage can take a result.
  always_comb begin
    req_ready = '0;
    if (transfer) begin
      req_ready = R'(1) << grant_idx;
    end
  end

  assign sel_data = req_data[grant_idx*N +: N];
  assign sel_amt  = req_amt[grant_idx*AW +: AW];
  assign ptr_next = (grant_idx == IW'(R - 1)) ? '0 : grant_idx + IW'(1);

  // Logarithmic shifter: one mux level per amount bit, shifting by 2^level, zero fill.
  always_comb begin
    shifted = sel_data;
    for (int lvl = 0; lvl < AW; lvl++) begin
      if (sel_amt[lvl]) begin
        shifted = shifted >> (1 << lvl);
      end
    end
  end

  // Output-stage occupancy: load on any transfer, empty only on a drain with no new transfer.
  always_comb begin
    state_next = state;
    if (transfer) begin
      state_next = FULL;
    end else if ((state == FULL) && res_ready) begin
      state_next = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Result payload and fairness pointer; both change only when an operand is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
      rr_ptr   <= '0;
    end else if (transfer) begin
      res_data <= shifted;
      res_id   <= grant_idx;
      rr_ptr   <= ptr_next;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // Saturating counters for completed handshakes and backpressure stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt     <= '0;
      busy_cycles <= '0;
    end else begin
      if (res_valid && res_ready && (ops_cnt != 16'hFFFF)) begin
        ops_cnt <= ops_cnt + 16'd1;
      end
      if ((state == FULL) && !res_ready && (busy_cycles != 16'hFFFF)) begin
        busy_cycles <= busy_cycles + 16'd1;
      end
    end
  end
`endif

endmodule
